// File: rtl/cache_fill_ctrl_pkg.sv
// rtl/cache_fill_ctrl_pkg.sv - shared types, geometry and address-field helpers for the fill controller
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_WRITE,
        S_RESPOND
    } state_e;

    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 2;
    localparam int INDEX_W        = 10;
    localparam int TAG_W          = 3;
    localparam int LINE_ADDR_W    = TAG_W + INDEX_W;
    localparam int WORD_ADDR_W    = TAG_W + INDEX_W + OFFSET_W;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [WORD_ADDR_W-1:0] a);
        return a[WORD_ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [WORD_ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [WORD_ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    // Line base address without the word offset (tag and index together).
    function automatic logic [LINE_ADDR_W-1:0] addr_line(input logic [WORD_ADDR_W-1:0] a);
        return a[WORD_ADDR_W-1:OFFSET_W];
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// rtl/cache_fill_ctrl_if.sv - core request/response, cache and memory signals of the fill controller
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32
);
    logic                  req_valid;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [WORD_W-1:0]     resp_data;
    logic                  resp_hit;
    logic [ADDR_W-1:0]     cache_addr;
    logic                  cache_hit;
    logic [WORD_W-1:0]     cache_rdata;
    logic                  cache_fill;
    logic [4*WORD_W-1:0]   cache_line;
    logic                  mem_rd;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ready;
    logic [WORD_W-1:0]     mem_rdata;

    // Controller side.
    modport master (
        input  req_valid, req_addr, cache_hit, cache_rdata, mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_hit,
               cache_addr, cache_fill, cache_line, mem_rd, mem_addr
    );

    // Core, cache and memory side.
    modport slave (
        output req_valid, req_addr, cache_hit, cache_rdata, mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_hit,
               cache_addr, cache_fill, cache_line, mem_rd, mem_addr
    );
endinterface

// File: rtl/cache_fill_ctrl_line_assembler.sv
// rtl/cache_fill_ctrl_line_assembler.sv - collects memory beats into a 4-word cache line
module line_assembler
    import cache_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               beat_en,
    input  logic [WORD_W-1:0]                  mem_rdata,
    output logic [WORDS_PER_LINE*WORD_W-1:0]   line,
    output logic [OFFSET_W-1:0]                beat,
    output logic                               last_beat
);
    logic [OFFSET_W-1:0]               beat_q, beat_d;
    logic [WORDS_PER_LINE*WORD_W-1:0]  line_q, line_d;

    // Place each accepted beat at its word slot; the counter wraps 3->0 on the final beat.
    always_comb begin
        beat_d = beat_q;
        line_d = line_q;
        if (clear) begin
            beat_d = '0;
        end else if (beat_en) begin
            line_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
            beat_d = beat_q + 1'b1;
        end
    end

    // Beat counter and line buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            line_q <= '0;
        end else begin
            beat_q <= beat_d;
            line_q <= line_d;
        end
    end

    assign line      = line_q;
    assign beat      = beat_q;
    assign last_beat = (beat_q == OFFSET_W'(WORDS_PER_LINE - 1));
endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - single-outstanding read controller with miss line fill and hit/miss statistics
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_fill_ctrl_if.master    bus,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      a_q, a_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic                   hit_q, hit_d;
    logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

    logic                   la_clear;
    logic                   beat_en;
    logic [4*WORD_W-1:0]    line;
    logic [OFFSET_W-1:0]    beat;
    logic                   last_beat;

    assign beat_en = bus.mem_rd & bus.mem_ready;

    line_assembler #(.WORD_W(WORD_W)) u_line_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (la_clear),
        .beat_en   (beat_en),
        .mem_rdata (bus.mem_rdata),
        .line      (line),
        .beat      (beat),
        .last_beat (last_beat)
    );

    // Next-state, strobes, saturating counters and response capture.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        word_d         = word_q;
        hit_d          = hit_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        la_clear       = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.cache_fill = 1'b0;
        bus.mem_rd     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    a_d     = bus.req_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (bus.cache_hit) begin
                    word_d = bus.cache_rdata;
                    hit_d  = 1'b1;
                    if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
                    state_d = S_RESPOND;
                end else begin
                    if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + 1'b1;
                    la_clear = 1'b1;
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready && last_beat) state_d = S_WRITE;
            end
            S_WRITE: begin
                bus.cache_fill = 1'b1;
                word_d  = line[addr_offset(a_q)*WORD_W +: WORD_W];
                hit_d   = 1'b0;
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                bus.resp_valid = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller state registers; reset abandons any fill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            word_q     <= '0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            word_q     <= word_d;
            hit_q      <= hit_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.resp_data  = word_q;
    assign bus.resp_hit   = hit_q;
    assign bus.cache_addr = a_q;
    assign bus.cache_line = line;
    assign bus.mem_addr   = {addr_line(a_q), beat};
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - scoreboard bench for cache_fill_ctrl
module tb_cache_fill_ctrl;
    localparam int ADDR_W = 15;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CNT_W-1:0] hit_count, miss_count;

    cache_fill_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    cache_fill_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [32:0]        resp_q[$];
    logic [ADDR_W-1:0]  addr_q[$];
    logic [127:0]       line_q[$];
    logic [ADDR_W-1:0]  fill_addr_q[$];

    int stall_n = 0;
    int stall_cnt = 0;
    int mem_rd_cycles = 0;
    int fill_cnt = 0;
    int resp_cnt = 0;
    int beats_xfer = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: applies the configured stall count before each beat and checks addresses.
    always @(negedge clk) begin
        if (bus.mem_rd) begin
            mem_rd_cycles++;
            if (addr_q.size() == 0) begin
                chk("mem_rd_unexpected", 128'(bus.mem_rd), 128'(0));
                bus.mem_ready = 1'b0;
            end else if (stall_cnt < stall_n) begin
                bus.mem_ready = 1'b0;
                chk("mem_addr_stalled", 128'(bus.mem_addr), 128'(addr_q[0]));
                stall_cnt++;
            end else begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h1000 + 32'(bus.mem_addr);
                chk("mem_addr_beat", 128'(bus.mem_addr), 128'(addr_q.pop_front()));
                stall_cnt = 0;
            end
        end else begin
            bus.mem_ready = 1'b0;
            stall_cnt = 0;
        end
    end

    // Fill and response monitor.
    always @(negedge clk) begin
        if (bus.resp_valid) resp_cnt++;
        if (bus.cache_fill) begin
            fill_cnt++;
            if (line_q.size() == 0) begin
                chk("fill_unexpected", 128'(bus.cache_fill), 128'(0));
            end else begin
                chk("cache_line", bus.cache_line, line_q.pop_front());
                chk("fill_addr", 128'(bus.cache_addr), 128'(fill_addr_q.pop_front()));
            end
        end
    end

    always @(posedge clk) if (bus.mem_rd && bus.mem_ready) beats_xfer++;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic push_miss(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] base;
        logic [127:0] ln;
        base = {addr[ADDR_W-1:2], 2'b00};
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(base + ADDR_W'(i));
            ln[32*i +: 32] = 32'h1000 + 32'(base) + 32'(i);
        end
        line_q.push_back(ln);
        fill_addr_q.push_back(addr);
    endtask

    // One request from an IDLE negedge through the response; returns at a negedge back in IDLE.
    task automatic do_req(input logic [ADDR_W-1:0] addr, input logic hit, input logic [31:0] rd,
                          input int stalls, input int exp_lat);
        int lat;
        int rd0;
        logic [32:0] e;
        bus.cache_hit   = hit;
        bus.cache_rdata = rd;
        stall_n         = stalls;
        rd0             = mem_rd_cycles;
        if (hit) begin
            resp_q.push_back({1'b1, rd});
            exp_hits = sat_inc(exp_hits);
        end else begin
            resp_q.push_back({1'b0, 32'h1000 + 32'(addr)});
            push_miss(addr);
            exp_misses = sat_inc(exp_misses);
        end
        chk("req_ready_idle", 128'(bus.req_ready), 128'(1));
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("resp_seen", 128'(bus.resp_valid), 128'(1));
        e = resp_q.pop_front();
        if (bus.resp_valid) begin
            chk("resp_data", 128'(bus.resp_data), 128'(e[31:0]));
            chk("resp_hit", 128'(bus.resp_hit), 128'(e[32]));
            chk("resp_latency", 128'(lat), 128'(exp_lat));
            chk("req_ready_busy", 128'(bus.req_ready), 128'(0));
            chk("hit_count", 128'(hit_count), 128'(exp_hits));
            chk("miss_count", 128'(miss_count), 128'(exp_misses));
        end
        if (hit) chk("hit_no_mem_rd", 128'(mem_rd_cycles), 128'(rd0));
        @(posedge clk);
        @(negedge clk);
        chk("resp_one_cycle", 128'(bus.resp_valid), 128'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 128'(bus.req_ready), 128'(1));
        chk("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
        chk("rst_mem_rd", 128'(bus.mem_rd), 128'(0));
        chk("rst_cache_fill", 128'(bus.cache_fill), 128'(0));
        chk("rst_hit_count", 128'(hit_count), 128'(0));
        chk("rst_miss_count", 128'(miss_count), 128'(0));
    endtask

    initial begin
        int t;
        int b0;
        int f0;
        int r0;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.cache_hit   = 1'b0;
        bus.cache_rdata = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Cold miss, hit, stalled miss.
        do_req(15'h0005, 1'b0, 32'h0, 0, 7);
        do_req(15'h0006, 1'b1, 32'hDEADBEEF, 0, 2);
        do_req(15'h7FF3, 1'b0, 32'h0, 3, 19);

        // Reset asserted mid-cycle after the second beat of a fill.
        bus.cache_hit = 1'b0;
        stall_n = 0;
        push_miss(15'h0155);
        bus.req_valid = 1'b1;
        bus.req_addr  = 15'h0155;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        b0 = beats_xfer;
        t = 0;
        while ((beats_xfer - b0) < 2 && t < 50) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("beats_before_reset", 128'(beats_xfer - b0), 128'(2));
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        addr_q.delete();
        line_q.delete();
        fill_addr_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
        f0 = fill_cnt;
        r0 = resp_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_fill_after_reset", 128'(fill_cnt), 128'(f0));
        chk("no_resp_after_reset", 128'(resp_cnt), 128'(r0));
        do_req(15'h0000, 1'b0, 32'h0, 0, 7);

        // Saturation of the hit counter, then one miss.
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            do_req(ADDR_W'(16 * i + 1), 1'b1, $urandom, 0, 2);
        end
        chk("hit_saturated", 128'(hit_count), 128'(15));
        do_req(15'h2A7E, 1'b0, 32'h0, 1, 11);
        chk("miss_after_sat", 128'(miss_count), 128'(1));
        chk("hit_still_sat", 128'(hit_count), 128'(15));
        chk("scoreboard_empty", 128'(resp_q.size() + addr_q.size() + line_q.size()), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
